// File: rtl/registr_decode.sv
// registr_decode: sequential restoring divider that unpacks a multiply-add
// result word Y = A*B + C into quotient A and remainder C, one quotient bit
// per clock, behind a start/busy/done handshake.
module registr_decode #(
    parameter int WIDTH_IN = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH_IN-1:0] DATA_IN,
    input  logic [7:0]          B,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [WIDTH_IN-1:0] A,
    output logic [7:0]          C,
    output logic                err,
    output logic                ovf
);

    localparam int CW = $clog2(WIDTH_IN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    // Dividend and quotient share one shift register: each step consumes the
    // MSB as the next dividend bit and shifts the new quotient bit into the
    // LSB, so after WIDTH_IN steps the register holds the full quotient.
    logic [WIDTH_IN-1:0] work;
    logic [WIDTH_IN-1:0] work_next;
    logic [7:0]          divisor;
    // Partial remainder. Between steps it is always below the divisor, so its
    // ninth bit is zero and only exists inside the trial value.
    logic [7:0]          rem;
    logic [7:0]          rem_next;
    logic [8:0]          trial;
    logic                qbit;
    logic [CW-1:0]       cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (B == 8'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One restoring-division step
    always_comb begin
        trial    = {rem, work[WIDTH_IN-1]};
        qbit     = 1'b0;
        rem_next = trial[7:0];
        if (trial >= {1'b0, divisor}) begin
            qbit     = 1'b1;
            rem_next = 8'(trial - {1'b0, divisor});
        end
        work_next = {work[WIDTH_IN-2:0], qbit};
    end

    // Datapath registers and result latching on DONE entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work    <= '0;
            divisor <= '0;
            rem     <= '0;
            cnt     <= '0;
            A       <= '0;
            C       <= '0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work    <= DATA_IN;
                        divisor <= B;
                        rem     <= '0;
                        cnt     <= CW'(WIDTH_IN - 1);
                        if (B == 8'd0) begin
                            A   <= '1;
                            C   <= DATA_IN[7:0];
                            err <= 1'b1;
                            ovf <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    work <= work_next;
                    rem  <= rem_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        A   <= work_next;
                        C   <= rem_next;
                        err <= 1'b0;
                        ovf <= |work_next[WIDTH_IN-1:8];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs come straight from the state register
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule
